// File: rtl/encoder_scan_if.sv
// Request/index stream bundle for encoder_scan.
// The upstream side drives in_valid/in_vec and the downstream side drives
// out_ready; the scanner sits between them on the slave modport.
interface encoder_scan_if #(
    parameter int N = 8
) ();
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    // Environment side: presents vectors and consumes indices.
    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last
    );

    // Scanner side.
    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last
    );
endinterface

// File: rtl/encoder_scan.sv
// Sequential N-bit request encoder.
// Accepts a request vector, then emits the binary index of each set bit,
// one per handshake, lowest-first (MSB_FIRST=0) or highest-first
// (MSB_FIRST=1). All-zero vectors are flagged with a one-cycle err_zero
// pulse instead of producing an index.
module encoder_scan #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    output logic          busy,
    output logic          err_zero,
    encoder_scan_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [N-1:0]     pending_reg;
    logic [N-1:0]     pending_next;
    logic             err_zero_reg;
    logic             err_zero_next;

    logic [N-1:0]     ord;      // pending, reordered so bit 0 is scanned first
    logic [N-1:0]     sel_ord;  // first set bit in scan order (one-hot)
    logic [N-1:0]     sel;      // same selection in natural bit order
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             in_ready;
    logic             out_valid;

    // Priority pick without a ripple chain: each bit is selected when it is
    // set and no earlier bit (in scan order) is set.
    for (genvar gi = 0; gi < N; gi++) begin : g_pick
        localparam logic [N-1:0] BELOW = (N'(1) << gi) - N'(1);
        assign ord[gi]     = MSB_FIRST ? pending_reg[N-1-gi] : pending_reg[gi];
        assign sel_ord[gi] = ord[gi] & ~(|(ord & BELOW));
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_unorder
        assign sel[gi] = MSB_FIRST ? sel_ord[N-1-gi] : sel_ord[gi];
    end

    // Binary-encode the one-hot selection; zero when nothing is pending.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    // Final index when the selected bit is the only one left.
    assign last = (pending_reg != '0) && ((pending_reg & ~sel) == '0);

    // Next-state, pending update and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        err_zero_next = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = !flush;
                if (bus.in_valid && !flush) begin
                    if (bus.in_vec != '0) begin
                        pending_next = bus.in_vec;
                        state_next   = SCAN;
                    end else begin
                        err_zero_next = 1'b1;
                    end
                end
            end
            SCAN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (flush) begin
                    // Abort wins over any handshake in the same cycle.
                    pending_next = '0;
                    state_next   = IDLE;
                end else if (bus.out_ready) begin
                    pending_next = pending_reg & ~sel;
                    if (last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    // State, pending vector and zero-vector pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            err_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            err_zero_reg <= err_zero_next;
        end
    end

    assign err_zero      = err_zero_reg;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = idx;
    assign bus.out_last  = last;

endmodule

// File: doc/encoder_scan.md
Name: encoder_scan

Overview:
- Parametrised, sequential successor to the team's 8:3 one-hot encoder.
- Accepts an N-bit request vector through a valid/ready handshake and emits the binary index of every set bit, one index per handshake, in priority order.
- Handles multi-hot and all-zero vectors explicitly; the older one-hot encoder silently mapped both to 0.
- Sits between interrupt/request collection logic and a downstream consumer that services one index at a time.

Parameters:
- N, 8, width of the request vector (N >= 1).
- MSB_FIRST, 0, scan order: 0 = lowest set index first, 1 = highest set index first.
- IDX_W, derived as max(1, clog2(N)), width of the index output; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the current scan.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  request vector.
- out_valid  output  1  out_idx/out_last are valid.
- out_ready  input  1  consumer accepts the current index.
- out_idx  output  IDX_W  binary index of the current set bit.
- out_last  output  1  current index is the final set bit of the vector.
- busy  output  1  scan in progress (state SCAN).
- err_zero  output  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the internal pending register clears to 0.
  - out_valid=0, busy=0, err_zero=0, out_idx=0, out_last=0.
  - in_ready is 1 once reset is released.
- State machine, two states IDLE and SCAN:
  - IDLE: in_ready = !flush.
  - Acceptance: in_valid & in_ready at edge t.
  - in_vec != 0: pending <= in_vec, go to SCAN, out_valid=1 from cycle t+1 (1-cycle latency).
  - in_vec == 0: stay in IDLE, err_zero=1 for exactly cycle t+1, no output produced.
  - SCAN: in_ready=0, busy=1, out_valid=1.
  - out_idx is the lowest set bit of pending (MSB_FIRST=0) or the highest (MSB_FIRST=1).
  - out_last = 1 iff pending has exactly one bit set.
  - out_idx/out_last are combinational from registered pending and stay stable while out_valid & !out_ready.
  - Handshake out_valid & out_ready: clear that bit in pending. If out_last, go to IDLE; otherwise the next index is presented in the following cycle.
- Throughput and timing:
  - Throughput is one index per cycle while out_ready stays high.
  - After the last handshake at edge t, in_ready=1 at cycle t+1. The minimum gap between vectors is 1 cycle.
  - in_vec is sampled only at acceptance; changes during SCAN are ignored.
- flush:
  - Has priority over everything except reset.
  - In SCAN it clears pending, returns to IDLE at the next edge, and drops out_valid with no completion.
  - A handshake in the flush cycle is discarded.
  - In IDLE, in_ready=0 during flush, so a simultaneous in_valid is not accepted.
- Boundaries:
  - N=1: IDX_W=1, out_idx always 0, out_last always 1.
  - All-ones vector yields N outputs; only the Nth has out_last=1.
  - Asserting rst_n low mid-scan drops all pending indices immediately.
- Protocol rules:
  - in_valid without acceptance has no effect.
  - err_zero never coincides with out_valid.

Test Plan:
- N=8, MSB_FIRST=0, in_vec=8'b0010_0100, out_ready=1 -> out_idx 2 (last=0) at t+1, 5 (last=1) at t+2; in_ready=1 at t+3.
- N=8, MSB_FIRST=1, in_vec=8'b1000_0001, out_ready low 3 cycles then high -> out_idx=7 held stable for 4 cycles, then 0 with out_last=1; exactly 2 handshakes.
- in_vec=8'h00 accepted -> err_zero=1 for one cycle, out_valid stays 0, in_ready stays 1; then in_vec=8'h80 -> out_idx=7, out_last=1.
- in_vec=8'hFF, out_ready=1 -> indices 0..7 on consecutive cycles, out_last only on 7; busy high for 8 cycles.
- in_vec=8'b0101_0000: after first handshake (idx 4), pulse flush -> out_valid=0 next cycle, idx 6 never appears; flush+in_valid same cycle -> not accepted.
- rst_n low asynchronously mid-scan of 8'hF0 -> outputs zero without waiting for clk; after release, new vector 8'h02 -> out_idx=1, out_last=1.
